// File: rtl/peripheral_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_adder_arbiter
//  Description : Round-robin arbiter and sequencer that shares one
//                combinational DATA_WIDTH-bit adder among NUM_REQ requesters.
//                It takes one operand pair at a time and drives it into the
//                adder. It then returns the captured sum, tagged with the
//                requester index, on a valid/ready response port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock; every state update is on the rising edge
//    rst        in   synchronous active-high reset
//    req_valid  in   [NUM_REQ]            per-requester operand valid
//    req_ip1    in   [NUM_REQ*DATA_WIDTH] flattened first operands
//    req_ip2    in   [NUM_REQ*DATA_WIDTH] flattened second operands
//    req_ready  out  [NUM_REQ]            one-hot grant, IDLE only
//    add_ip1    out  [DATA_WIDTH]         registered operand to adder ip1
//    add_ip2    out  [DATA_WIDTH]         registered operand to adder ip2
//    add_out    in   [DATA_WIDTH+1]       combinational sum from the adder
//    rsp_valid  out                       result available (RESP state)
//    rsp_id     out  [ID_WIDTH]           requester that owns the result
//    rsp_out    out  [DATA_WIDTH+1]       captured sum
//    rsp_ready  in                        response consumer ready
//    busy       out                       state is not IDLE
// ============================================================================
module peripheral_adder_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ip1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ip2,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         add_ip1,
  output logic [DATA_WIDTH-1:0]         add_ip2,
  input  logic [DATA_WIDTH:0]           add_out,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH:0]           rsp_out,
  input  logic                          rsp_ready,
  output logic                          busy
);

  // The search index carries one extra bit so that rr_ptr + offset never
  // overflows before it is folded back into 0..NUM_REQ-1.
  localparam logic [ID_WIDTH:0]   c_num_req  = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] c_last_idx = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [ID_WIDTH-1:0]     r_rr_ptr;
  logic [DATA_WIDTH-1:0]   r_op1;
  logic [DATA_WIDTH-1:0]   r_op2;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH:0]     r_sum;

  logic                    w_any;
  logic [ID_WIDTH-1:0]     w_winner;
  logic [ID_WIDTH:0]       w_idx;
  logic [NUM_REQ-1:0]      w_grant;
  logic [ID_WIDTH-1:0]     w_next_ptr;
  logic [DATA_WIDTH-1:0]   w_sel_ip1;
  logic [DATA_WIDTH-1:0]   w_sel_ip2;
  logic                    w_accept;
  logic                    w_capture;

  // --------------------------------------------------------------------------
  // Round-robin winner search: scan NUM_REQ positions starting at rr_ptr,
  // ascending with wrap; the first valid requester wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
      if (w_idx >= c_num_req) begin
        w_idx = w_idx - c_num_req;
      end
      if (!w_any && req_valid[w_idx[ID_WIDTH-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_idx[ID_WIDTH-1:0];
      end
    end
  end

  // One-hot form of the winner; all zero when nobody is requesting.
  always_comb begin
    w_grant = '0;
    if (w_any) begin
      w_grant[w_winner] = 1'b1;
    end
  end

  // Pointer moves to the slot just after the winner so that winner becomes
  // the lowest priority on the next arbitration.
  always_comb begin
    if (w_winner == c_last_idx) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_winner + ID_WIDTH'(1);
    end
  end

  // Operand mux driven by the one-hot grant (AND-OR, no priority chain).
  always_comb begin
    w_sel_ip1 = '0;
    w_sel_ip2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_ip1 = req_ip1[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_ip2 = req_ip2[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The grant goes only to a valid requester, so presenting it means
        // the transfer completes on this edge.
        if (w_any) begin
          req_ready    = w_grant;
          w_accept     = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture    = 1'b1;
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Round-robin pointer; a single requester needs no pointer at all.
  // --------------------------------------------------------------------------
  generate
    if (NUM_REQ > 1) begin : g_rr_multi
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rr_ptr <= '0;
        end else if (w_accept) begin
          r_rr_ptr <= w_next_ptr;
        end
      end
    end else begin : g_rr_single
      assign r_rr_ptr = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Datapath registers. Operands are not cleared after use, so the adder
  // inputs stay quiet until the next accept.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1 <= '0;
      r_op2 <= '0;
      r_id  <= '0;
      r_sum <= '0;
    end else begin
      if (w_accept) begin
        r_op1 <= w_sel_ip1;
        r_op2 <= w_sel_ip2;
        r_id  <= w_winner;
      end
      if (w_capture) begin
        r_sum <= add_out;
      end
    end
  end

  assign add_ip1   = r_op1;
  assign add_ip2   = r_op2;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_id;
  assign rsp_out   = r_sum;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
